// File: rtl/core_ctrl_if.sv
// core_ctrl_if: handshake, parser-enable and strobe bundle between core_ctrl_fsm and the core
interface core_ctrl_if #(
    parameter int OP_BITS   = 7,
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic                 imem_req;
    logic                 imem_ready;
    logic                 ir_load;
    logic [OP_BITS-1:0]   op;
    logic                 regw_en;
    logic                 memr_en;
    logic                 memw_en;
    logic                 br_en;
    logic                 j_en;
    logic                 br_taken;
    logic                 dmem_req;
    logic                 dmem_we;
    logic                 dmem_ready;
    logic                 pc_load;
    logic                 pc_inc;
    logic                 rf_we;
    logic                 wb_sel_mem;
    logic                 halted;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] instret;

    modport master (
        input  start, imem_ready, op, regw_en, memr_en, memw_en, br_en, j_en, br_taken, dmem_ready,
        output imem_req, ir_load, dmem_req, dmem_we, pc_load, pc_inc, rf_we, wb_sel_mem, halted,
               illegal, instret
    );

    modport slave (
        output start, imem_ready, op, regw_en, memr_en, memw_en, br_en, j_en, br_taken, dmem_ready,
        input  imem_req, ir_load, dmem_req, dmem_we, pc_load, pc_inc, rf_we, wb_sel_mem, halted,
               illegal, instret
    );
endinterface

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle fetch/decode/exec/mem/writeback sequencer with trap and instret
module core_ctrl_fsm #(
    parameter int OP_BITS   = 7,
    parameter int CNT_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input logic         clk,
    input logic         rst_n,
    core_ctrl_if.master bus
);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    localparam logic [OP_BITS-1:0] OPC_LOAD     = OP_BITS'(7'b0000011);
    localparam logic [OP_BITS-1:0] OPC_MISC_MEM = OP_BITS'(7'b0001111);
    localparam logic [OP_BITS-1:0] OPC_OP_IMM   = OP_BITS'(7'b0010011);
    localparam logic [OP_BITS-1:0] OPC_AUIPC    = OP_BITS'(7'b0010111);
    localparam logic [OP_BITS-1:0] OPC_STORE    = OP_BITS'(7'b0100011);
    localparam logic [OP_BITS-1:0] OPC_OP       = OP_BITS'(7'b0110011);
    localparam logic [OP_BITS-1:0] OPC_LUI      = OP_BITS'(7'b0110111);
    localparam logic [OP_BITS-1:0] OPC_BRANCH   = OP_BITS'(7'b1100011);
    localparam logic [OP_BITS-1:0] OPC_JALR     = OP_BITS'(7'b1100111);
    localparam logic [OP_BITS-1:0] OPC_JAL      = OP_BITS'(7'b1101111);
    localparam logic [OP_BITS-1:0] OPC_SYSTEM   = OP_BITS'(7'b1110011);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t               state_q, state_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic                 illegal_q, illegal_d;
    logic                 legal_op;
    logic                 timeout;

    // next state, wait counter and strobes; every retiring cycle pulses exactly one PC strobe
    always_comb begin
        state_d        = state_q;
        wait_d         = '0;
        illegal_d      = illegal_q;
        bus.imem_req   = 1'b0;
        bus.ir_load    = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.rf_we      = 1'b0;
        bus.wb_sel_mem = 1'b0;
        bus.halted     = 1'b0;
        legal_op       = bus.op inside {OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
                                        OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
        timeout        = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
        case (state_q)
            S_IDLE: state_d = bus.start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_load = 1'b1;
                    state_d     = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (bus.op == OPC_SYSTEM) begin
                    state_d = S_TRAP;
                end else if (!legal_op) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.memr_en || bus.memw_en) begin
                    state_d = S_MEM;
                end else if (bus.br_en) begin
                    bus.pc_load = bus.br_taken;
                    bus.pc_inc  = ~bus.br_taken;
                    state_d     = S_FETCH;
                end else if (bus.regw_en) begin
                    state_d = S_WB;
                end else begin
                    bus.pc_inc = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = bus.memw_en;
                if (bus.dmem_ready) begin
                    bus.pc_inc = bus.memw_en;
                    state_d    = bus.memw_en ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                bus.rf_we      = 1'b1;
                bus.wb_sel_mem = bus.memr_en;
                bus.pc_load    = bus.j_en;
                bus.pc_inc     = ~bus.j_en;
                state_d        = S_FETCH;
            end
            S_TRAP: bus.halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
        instret_d   = instret_q + CNT_WIDTH'(bus.pc_load | bus.pc_inc);
        bus.illegal = illegal_q;
        bus.instret = instret_q;
    end

    // state, wait counter, retired count and trap cause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: randomized scoreboard bench for core_ctrl_fsm with an opcode-level reference model
module tb_core_ctrl_fsm;
    localparam int CW = 4;
    localparam int TO = 4;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JUMP = 4, K_NOP = 5, K_SYS = 6, K_ILL = 7;

    typedef struct {
        bit trap;
        bit ill;
        bit pl;
        bit pi;
        bit rw;
        bit ws;
        bit we;
        int ic;
        int dc;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mcnt = 0;
    exp_t q[$];
    logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                                   7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111};

    core_ctrl_if #(.OP_BITS(7), .CNT_WIDTH(CW)) bus ();
    core_ctrl_fsm #(.OP_BITS(7), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_class(input logic [6:0] o);
        case (o)
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BR;
            7'b1101111, 7'b1100111: return K_JUMP;
            7'b0010011, 7'b0110111, 7'b0010111, 7'b0110011: return K_ALU;
            7'b0001111: return K_NOP;
            7'b1110011: return K_SYS;
            default: return K_ILL;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.start = 0; bus.imem_ready = 0; bus.op = '0; bus.regw_en = 0; bus.memr_en = 0;
        bus.memw_en = 0; bus.br_en = 0; bus.j_en = 0; bus.br_taken = 0; bus.dmem_ready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        q.delete();
        mcnt = 0;
        clear_inputs();
        repeat (2) step();
        chk("rst_outputs", int'({bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.pc_load, bus.pc_inc,
                                 bus.rf_we, bus.wb_sel_mem, bus.halted, bus.illegal, bus.instret}), 0);
        rst_n = 1;
        step();
        chk("idle_no_fetch", int'(bus.imem_req), 0);
    endtask

    task automatic pulse_start();
        bus.start = 1;
        step();
        bus.start = 0;
    endtask

    task automatic wait_req(input bit dmem, output bit ok);
        for (int n = 0; n < 20; n++) begin
            if (dmem ? bus.dmem_req : bus.imem_req) break;
            step();
        end
        ok = dmem ? bus.dmem_req : bus.imem_req;
        chk(dmem ? "dmem_req_wait" : "imem_req_wait", int'(ok), 1);
    endtask

    task automatic wait_halt();
        for (int n = 0; n < 20; n++) begin
            if (bus.halted) break;
            step();
        end
        chk("halt_wait", int'(bus.halted), 1);
        step();
    endtask

    // expected response from the opcode's architectural class; dw<0 means dmem never answers
    task automatic issue(input logic [6:0] o, input logic bt, input int iw, input int dw);
        exp_t e;
        bit   ok;
        int   k;
        k = op_class(o);
        e = '{default: 0};
        e.cnt = mcnt;
        e.ic = iw + 1;
        if (k == K_SYS || k == K_ILL) begin
            e.trap = 1;
            e.ill = (k == K_ILL);
        end else if ((k == K_LOAD || k == K_STORE) && dw < 0) begin
            e.trap = 1;
            e.ill = 1;
            e.dc = TO;
            e.we = (k == K_STORE);
        end else begin
            e.pl = (k == K_JUMP) || (k == K_BR && bt);
            e.pi = !e.pl;
            e.rw = (k == K_ALU || k == K_JUMP || k == K_LOAD);
            e.ws = (k == K_LOAD);
            e.we = (k == K_STORE);
            e.dc = (k == K_LOAD || k == K_STORE) ? dw + 1 : 0;
            mcnt = (mcnt + 1) % (1 << CW);
        end
        q.push_back(e);
        wait_req(0, ok);
        if (!ok) return;
        repeat (iw) step();
        bus.imem_ready = 1;
        bus.op = o;
        bus.regw_en = (k == K_ALU || k == K_JUMP || k == K_LOAD);
        bus.memr_en = (k == K_LOAD);
        bus.memw_en = (k == K_STORE);
        bus.br_en = (k == K_BR);
        bus.j_en = (k == K_JUMP);
        bus.br_taken = bt;
        step();
        bus.imem_ready = 0;
        if (k == K_LOAD || k == K_STORE) begin
            wait_req(1, ok);
            if (!ok || dw < 0) return;
            repeat (dw) step();
            bus.dmem_ready = 1;
            step();
            bus.dmem_ready = 0;
        end
    endtask

    // monitor: accumulates per-instruction activity and scores each retirement or trap entry
    initial begin
        int   ic, dc, rc;
        bit   we, ph, tr;
        exp_t e;
        ic = 0; dc = 0; rc = 0; we = 0; ph = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ic = 0; dc = 0; rc = 0; we = 0; ph = 0;
            end else begin
                ic += int'(bus.imem_req);
                dc += int'(bus.dmem_req);
                rc += int'(bus.rf_we);
                we |= bus.dmem_req & bus.dmem_we;
                chk("pc_exclusive", int'(bus.pc_load & bus.pc_inc), 0);
                tr = bus.halted && !ph;
                if (bus.pc_load || bus.pc_inc || tr) begin
                    if (q.size() == 0) begin
                        chk("unexpected_event", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        chk("event_is_trap", int'(tr), int'(e.trap));
                        chk("illegal", int'(bus.illegal), int'(e.ill));
                        chk("pc_load", int'(bus.pc_load), int'(e.pl));
                        chk("pc_inc", int'(bus.pc_inc), int'(e.pi));
                        chk("rf_we_cycles", rc, int'(e.rw));
                        chk("wb_sel_mem", int'(bus.wb_sel_mem), int'(e.ws));
                        chk("dmem_we", int'(we), int'(e.we));
                        chk("imem_req_cycles", ic, e.ic);
                        chk("dmem_req_cycles", dc, e.dc);
                        chk("instret", int'(bus.instret), e.cnt);
                    end
                    ic = 0; dc = 0; rc = 0; we = 0;
                end
                ph = bus.halted;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        do_reset();
        pulse_start();
        issue(7'b0110011, 0, 0, 0);
        issue(7'b0000011, 0, 0, 3);
        issue(7'b1100011, 1, 0, 0);
        issue(7'b1100011, 0, 1, 0);
        issue(7'b0100011, 0, 3, 0);
        issue(7'b1101111, 0, 0, 0);
        issue(7'b0001111, 0, 2, 0);
        issue(7'b0100011, 0, 0, 3);
        for (int i = 0; i < 40; i++)
            issue(legal_ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        issue(7'b1111111, 0, 1, 0);
        wait_halt();
        repeat (3) pulse_start();
        step();
        chk("trap_sticky_halted", int'(bus.halted), 1);
        chk("trap_no_fetch", int'(bus.imem_req), 0);
        chk("trap_illegal", int'(bus.illegal), 1);
        chk("trap_instret_hold", int'(bus.instret), mcnt);

        do_reset();
        pulse_start();
        issue(7'b1110011, 0, 1, 0);
        wait_halt();
        chk("system_not_illegal", int'(bus.illegal), 0);

        do_reset();
        pulse_start();
        q.push_back('{trap: 1, ill: 1, ic: TO, default: 0});
        wait_halt();

        do_reset();
        pulse_start();
        issue(7'b0000011, 0, 0, -1);
        wait_halt();

        do_reset();
        pulse_start();
        issue(7'b0110011, 0, 0, 0);
        issue(7'b0000011, 0, 1, -1);
        repeat (2) step();
        chk("pre_rst_instret", int'(bus.instret), 1);
        chk("pre_rst_dmem_req", int'(bus.dmem_req), 1);
        #2 rst_n = 0;
        #1;
        chk("rst_dmem_req_drop", int'(bus.dmem_req), 0);
        chk("rst_instret_clear", int'(bus.instret), 0);
        chk("rst_not_halted", int'(bus.halted), 0);
        q.delete();
        mcnt = 0;
        step();
        rst_n = 1;
        step();
        chk("idle_after_rst", int'(bus.imem_req), 0);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
